// File: rtl/dbg_exec_tracer_if.sv
// Execute-stage trace bus: core-side op fields in, ring peek and status out.
interface dbg_exec_tracer_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic            stall;
  logic [XLEN-1:0] pc;
  logic [4:0]      rd;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] data2;
  logic            bj_en;
  logic [XLEN-1:0] bj_pc;
  logic            wfi_op;
  logic [AW-1:0]   peek_idx;
  logic [XLEN-1:0] peek_pc;
  logic            peek_valid;
  logic [31:0]     retire_cnt;
  logic [1:0]      state;

  modport master (
    output stall, pc, rd, result, data2, bj_en, bj_pc, wfi_op, peek_idx,
    input  peek_pc, peek_valid, retire_cnt, state
  );

  modport slave (
    input  stall, pc, rd, result, data2, bj_en, bj_pc, wfi_op, peek_idx,
    output peek_pc, peek_valid, retire_cnt, state
  );
endinterface

// File: rtl/dbg_exec_tracer.sv
// Execute-stage debug tracer: last-DEPTH op ring, retire counter, WFI drain/dump/exit.
// Optional DBG_TRACE_BJ_ONLY_EN restricts capture and counting to taken branch/jump ops.
module dbg_exec_tracer #(
  parameter int unsigned     XLEN       = 64,
  parameter int unsigned     DEPTH      = 16,
  parameter int unsigned     EXIT_DELAY = 2,
  parameter logic [XLEN-1:0] PC_LO      = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] PC_HI      = {XLEN{1'b1}}
) (
  input logic              clk,
  input logic              rst_n,
  dbg_exec_tracer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] data2;
    logic            bj_en;
    logic [XLEN-1:0] bj_pc;
  } entry_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [AW-1:0]   wr_ptr_r;
  logic [FW-1:0]   fill_r;
  logic [31:0]     retire_cnt_r;
  logic [31:0]     drain_cnt_r;
  logic [31:0]     drain_nx_s;
  logic [AW-1:0]   dump_ptr_r;
  logic [AW-1:0]   dump_nx_s;
  entry_t          ring_r [DEPTH];

  logic            lo_ok_s;
  logic            hi_ok_s;
  logic            kind_ok_s;
  logic            capture_s;
  entry_t          entry_s;
  logic [AW-1:0]   peek_phys_s;
  logic [AW-1:0]   dump_idx_s;
  logic            peek_valid_s;

  // Open-ended window bounds are trivially true; skip the compare to avoid constant comparisons.
  if (PC_LO == {XLEN{1'b0}}) begin : g_lo_open
    assign lo_ok_s = 1'b1;
  end else begin : g_lo_cmp
    assign lo_ok_s = (bus.pc >= PC_LO);
  end

  if (PC_HI == {XLEN{1'b1}}) begin : g_hi_open
    assign hi_ok_s = 1'b1;
  end else begin : g_hi_cmp
    assign hi_ok_s = (bus.pc <= PC_HI);
  end

`ifdef DBG_TRACE_BJ_ONLY_EN
  assign kind_ok_s = bus.bj_en;
`else
  assign kind_ok_s = 1'b1;
`endif

  assign capture_s = (state_r == ST_RUN) && !bus.stall && lo_ok_s && hi_ok_s && kind_ok_s;

  assign entry_s = '{pc: bus.pc, rd: bus.rd, result: bus.result, data2: bus.data2,
                     bj_en: bus.bj_en, bj_pc: bus.bj_pc};

  // Oldest entry sits fill slots behind the write pointer; a full ring wraps onto wr_ptr itself.
  assign dump_idx_s   = wr_ptr_r - fill_r[AW-1:0] + dump_ptr_r;
  assign peek_phys_s  = wr_ptr_r - AW'(1) - bus.peek_idx;
  assign peek_valid_s = ({1'b0, bus.peek_idx} < fill_r);

  assign bus.peek_valid = peek_valid_s;
  assign bus.peek_pc    = peek_valid_s ? ring_r[peek_phys_s].pc : {XLEN{1'b0}};
  assign bus.retire_cnt = retire_cnt_r;
  assign bus.state      = state_r;

  // Ring storage; contents are only meaningful below fill, so no reset is needed.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      ring_r[wr_ptr_r] <= entry_s;
    end
  end

  // State, pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RUN;
      wr_ptr_r     <= {AW{1'b0}};
      fill_r       <= {FW{1'b0}};
      retire_cnt_r <= 32'd0;
      drain_cnt_r  <= 32'd0;
      dump_ptr_r   <= {AW{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      drain_cnt_r <= drain_nx_s;
      dump_ptr_r  <= dump_nx_s;
      if (capture_s) begin
        wr_ptr_r     <= wr_ptr_r + AW'(1);
        retire_cnt_r <= retire_cnt_r + 32'd1;
        if (fill_r != FW'(DEPTH)) begin
          fill_r <= fill_r + FW'(1);
        end
      end
    end
  end

  // Next-state logic for the run / drain / dump / done sequence.
  always_comb begin
    state_nx_s = state_r;
    drain_nx_s = drain_cnt_r;
    dump_nx_s  = dump_ptr_r;
    case (state_r)
      ST_RUN: begin
        if (bus.wfi_op) begin
          state_nx_s = ST_DRAIN;
          drain_nx_s = 32'(EXIT_DELAY - 1);
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == 32'd0) begin
          state_nx_s = ST_DUMP;
          dump_nx_s  = {AW{1'b0}};
        end else begin
          drain_nx_s = drain_cnt_r - 32'd1;
        end
      end
      ST_DUMP: begin
        if ((fill_r == {FW{1'b0}}) || ({1'b0, dump_ptr_r} == (fill_r - FW'(1)))) begin
          state_nx_s = ST_DONE;
        end else begin
          dump_nx_s = dump_ptr_r + AW'(1);
        end
      end
      ST_DONE: begin
        state_nx_s = ST_DONE;
      end
      default: begin
        state_nx_s = ST_RUN;
      end
    endcase
  end

`ifndef SYNTHESIS
  // Simulation-only console output: per-op trace, oldest-first dump, exit summary.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (capture_s) begin
        $display("[exec] pc=%h rd=x%0d result=%h rs2=%h", bus.pc, bus.rd, bus.result, bus.data2);
        if (bus.bj_en) begin
          $display("[exec]   bj -> %h", bus.bj_pc);
        end
      end
      if ((state_r == ST_DUMP) && (fill_r != {FW{1'b0}})) begin
        $display("[hist] pc=%h rd=x%0d result=%h rs2=%h bj=%0d target=%h",
                 ring_r[dump_idx_s].pc, ring_r[dump_idx_s].rd, ring_r[dump_idx_s].result,
                 ring_r[dump_idx_s].data2, ring_r[dump_idx_s].bj_en, ring_r[dump_idx_s].bj_pc);
      end
      if (state_r == ST_DONE) begin
        $display("[exit] WFI reached, retired ops: %0d", retire_cnt_r);
        $finish;
      end
    end
  end
`endif

endmodule
